stc0_egress_serializer: RTL
===========================

// Module: stc0_egress_serializer
// PURPOSE
//  Final datapath stage: buffers the 32-bit words emitted by the egress stage in a small FIFO
//  and serializes them onto the 8-bit ED/EValid byte interface, MSB byte first, one byte per clock.
//  Provides Ready backpressure upstream with slack for in-flight words; counts dropped words.
// PARAMETERS
//  DEPTH        8   FIFO depth in 32-bit words (power of two, >=4)
//  DEPTH_LOG2   3   log2(DEPTH)
//  READY_SLACK  2   Ready deasserts when free entries <= READY_SLACK
// PORTS
//  ClkIngress      in   1   single clock, all logic rising-edge
//  ARstb           in   1   asynchronous active-low reset
//  WriteData       in   32  word from egress stage, {Cr,Ci} or {Dr,Di}
//  WriteDataValid  in   1   WriteData valid this cycle
//  Ready           out  1   upstream may issue words
//  Data            out  8   serialized byte
//  DataValid       out  1   Data valid this cycle
//  Level           out  DEPTH_LOG2+1  current FIFO occupancy
//  Overflow        out  1   sticky: a word was dropped
// BEHAVIOUR
//  Reset (ARstb low, async): Data=0, DataValid=0, Ready=0, Level=0, Overflow=0, FIFO empty, FSM IDLE.
//   Ready rises first edge after ARstb release (registered).
//  FIFO write: accepted iff WriteDataValid && Level<DEPTH (registered Level; a same-cycle pop
//   does NOT free space). Write at full: word dropped, Overflow set, cleared only by reset.
//  Ready (registered) = (DEPTH-Level_next) > READY_SLACK.
//  Level_next = Level + push - pop; simultaneous push/pop leaves Level unchanged.
//  FSM: IDLE -> B0 when FIFO non-empty (pop, load shift reg); B0->B1->B2->B3 one per clock;
//   B3 -> B0 with pop if FIFO non-empty, else -> IDLE (or CK when STC0_EGRESS_CKSUM_EN).
//  Byte order: B0=[31:24], B1=[23:16], B2=[15:8], B3=[7:0]; Data/DataValid registered.
//  Latency: word accepted at edge N into empty FIFO, serializer IDLE -> B0 byte on Data in
//   cycle N+2; subsequent words stream with zero gap cycles.
//  DataValid low in IDLE; Data holds its last value while DataValid=0.
//  No downstream backpressure: consumer must accept every byte while DataValid=1.
//  Pointers wrap modulo DEPTH; Level saturates logically at DEPTH (never exceeds).
//  Reset mid-word: partial word discarded, no further bytes emitted.
// CONFIGURATION
//  `STC0_EGRESS_CKSUM_EN defined: after B3 a 5th byte (state CK) = XOR of the 4 data bytes;
//   B3->CK->B0/IDLE; frame = 5 bytes, throughput 4/5.
//  Undefined: 4-byte frames, CK state and XOR logic absent.
// STRUCTURE
//  stc0_egress.vh: state encodings (ST_IDLE,ST_B0..ST_B3,ST_CK), byte count constants.
//  Sub-module stc0_sync_fifo (DW, DEPTH, DEPTH_LOG2): reg array, wr/rd ptrs, Level,
//   combinational head read; instantiated once; serializer FSM in this module.
// TESTING
//  Single word 0x11223344 into idle block -> bytes 11,22,33,44 in cycles N+2..N+5, DataValid
//   low after.
//  8 back-to-back words -> 32 contiguous valid bytes, no gaps; Ready falls when Level>=6.
//  Push 12 words back-to-back ignoring Ready -> words beyond capacity dropped, Overflow=1,
//   stays set.
//  Push and pop in same cycle at Level=3 -> Level stays 3.
//  Assert ARstb low during B1 -> Data=0, DataValid=0 async, Level=0, Overflow=0; next word
//   streams cleanly.
//  CKSUM_EN: 0xA5A50F0F -> A5,A5,0F,0F,00; 0x01020408 -> 01,02,04,08,0F.

Source files
------------

// File: rtl/stc0_egress_pkg.sv
// Shared state encoding and byte helpers for the STC0 egress serializer.
// Build option STC0_EGRESS_CKSUM_EN appends an XOR check byte (state ST_CK) to every frame.
package stc0_egress_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
`ifdef STC0_EGRESS_CKSUM_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
`ifdef STC0_EGRESS_CKSUM_EN
        ,
        ST_CK   = 3'd5
`endif
    } ser_state_e;

`ifdef STC0_EGRESS_CKSUM_EN
    function automatic logic [BYTE_W-1:0] xor_fold(input logic [WORD_W-1:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction
`endif

    // Byte presented on the wire while the serializer sits in state st.
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [WORD_W-1:0] w,
                                                     input ser_state_e      st);
        logic [BYTE_W-1:0] b;
        case (st)
            ST_B0:   b = w[31:24];
            ST_B1:   b = w[23:16];
            ST_B2:   b = w[15:8];
            ST_B3:   b = w[7:0];
`ifdef STC0_EGRESS_CKSUM_EN
            ST_CK:   b = xor_fold(w);
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stc0_sync_fifo.sv
// Single-clock word FIFO with registered occupancy and combinational head read.
// Writes at full and reads at empty are ignored so the pointers can never corrupt.
module stc0_sync_fifo
    import stc0_egress_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rd_en,
    output logic [DW-1:0]         head,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   level_next,
    output logic                  full,
    output logic                  empty
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int PW = DEPTH_LOG2;

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_next_s;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign full    = (level_r == LW'(DEPTH));
    assign empty   = (level_r == LW'(0));
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Occupancy update; a simultaneous push and pop cancel out.
    always_comb begin
        level_next_s = level_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= LW'(0);
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_next_s;
        end
    end

    // Storage array; contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign level      = level_r;
    assign level_next = level_next_s;

endmodule

// File: rtl/stc0_egress_serializer.sv
// Buffers 32-bit egress words and serializes them MSB byte first onto Data/DataValid.
// Build option STC0_EGRESS_CKSUM_EN adds a fifth XOR check byte per word.
module stc0_egress_serializer
    import stc0_egress_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int DEPTH_LOG2  = 3,
    parameter int READY_SLACK = 2
) (
    input  logic                  ClkIngress,
    input  logic                  ARstb,
    input  logic [31:0]           WriteData,
    input  logic                  WriteDataValid,
    output logic                  Ready,
    output logic [7:0]            Data,
    output logic                  DataValid,
    output logic [DEPTH_LOG2:0]   Level,
    output logic                  Overflow
);

    localparam int LW = DEPTH_LOG2 + 1;

    ser_state_e        state_r;
    ser_state_e        state_next_s;
    logic [WORD_W-1:0] word_r;
    logic [WORD_W-1:0] head_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [LW-1:0]     level_s;
    logic [LW-1:0]     level_next_s;
    logic [LW-1:0]     free_next_s;
    logic [7:0]        data_r;
    logic              data_valid_r;
    logic              ready_r;
    logic              overflow_r;

    // Space is judged on the registered level only, so a same-cycle pop never admits a word.
    assign push_s      = WriteDataValid && !full_s;
    assign free_next_s = LW'(DEPTH) - level_next_s;

    stc0_sync_fifo #(
        .DW         (WORD_W),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (ClkIngress),
        .rst_n      (ARstb),
        .wr_en      (push_s),
        .wr_data    (WriteData),
        .rd_en      (pop_s),
        .head       (head_s),
        .level      (level_s),
        .level_next (level_next_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Next state and pop; a new word is loaded only when idle or at the end of a frame.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_B0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_B0: state_next_s = ST_B1;
            ST_B1: state_next_s = ST_B2;
            ST_B2: state_next_s = ST_B3;
`ifdef STC0_EGRESS_CKSUM_EN
            ST_B3: state_next_s = ST_CK;
            ST_CK: begin
`else
            ST_B3: begin
`endif
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_B0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge ClkIngress or negedge ARstb) begin
        if (!ARstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Word latch, registered byte output, Ready and sticky Overflow.
    always_ff @(posedge ClkIngress or negedge ARstb) begin
        if (!ARstb) begin
            word_r       <= 32'h0000_0000;
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            ready_r      <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                word_r <= head_s;
            end else begin
                word_r <= word_r;
            end
            if (state_r != ST_IDLE) begin
                data_r       <= frame_byte(word_r, state_r);
                data_valid_r <= 1'b1;
            end else begin
                data_r       <= data_r;
                data_valid_r <= 1'b0;
            end
            ready_r <= (free_next_s > LW'(READY_SLACK));
            if (WriteDataValid && full_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign Data      = data_r;
    assign DataValid = data_valid_r;
    assign Ready     = ready_r;
    assign Level     = level_s;
    assign Overflow  = overflow_r;

endmodule
